// File: rtl/pcie_datalink_pkg.sv
// pcie_datalink_pkg: shared token codes, framer states and beat positions for the PCIe TX path.
package pcie_datalink_pkg;

    localparam logic [7:0] TOK_SDP = 8'h5C;
    localparam logic [7:0] TOK_STP = 8'hFB;
    localparam logic [7:0] TOK_END = 8'hFD;
    localparam logic [7:0] TOK_EDB = 8'hFE;

    localparam int TUSER_NULLIFY_BIT = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_DLLP, ST_TLP, ST_DROP} framer_state_e;

    typedef enum logic [1:0] {POS_FIRST, POS_MID, POS_LAST} beat_pos_e;

endpackage

// File: rtl/pcie_tx_token_align.sv
// pcie_tx_token_align: shifts a beat up one byte behind the carried byte and inserts the start/end token.
module pcie_tx_token_align
    import pcie_datalink_pkg::*;
(
    input  logic [31:0] i_beat,
    input  logic [3:0]  i_keep,
    input  logic [7:0]  i_carry,
    input  beat_pos_e   i_pos,
    input  logic        i_is_tlp,
    input  logic        i_nullify,
    output logic [31:0] o_data,
    output logic [3:0]  o_kchar,
    output logic        o_malformed
);

    logic       w_keep_ok;
    logic [7:0] w_end;
    logic [7:0] w_start;

    assign w_keep_ok = i_keep == 4'b0011;
    assign w_end     = (!w_keep_ok || i_nullify) ? TOK_EDB : TOK_END;
    assign w_start   = i_is_tlp ? TOK_STP : TOK_SDP;

    // Last beat keeps at most two payload bytes; slots outside keep go out as zero.
    assign o_data = (i_pos == POS_FIRST) ? {i_beat[23:0], w_start} :
                    (i_pos == POS_LAST)  ? {w_end, i_keep[1] ? i_beat[15:8] : 8'h00,
                                            i_keep[0] ? i_beat[7:0] : 8'h00, i_carry} :
                                           {i_beat[23:0], i_carry};

    assign o_kchar     = (i_pos == POS_FIRST) ? 4'b0001 : (i_pos == POS_LAST) ? 4'b1000 : 4'b0000;
    assign o_malformed = (i_pos == POS_LAST) && !w_keep_ok;

endmodule

// File: rtl/pcie_phy_tx_framer.sv
// pcie_phy_tx_framer: arbitrates DLLP/TLP streams at packet boundaries and frames them into
// a single registered K-flagged symbol stream for the PHY lane.
module pcie_phy_tx_framer
    import pcie_datalink_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int USER_WIDTH     = 3,
    parameter int MAX_DLLP_BURST = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] s_axis_dllp_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_dllp_tkeep_i,
    input  logic                  s_axis_dllp_tvalid_i,
    input  logic                  s_axis_dllp_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_dllp_tuser_i,
    output logic                  s_axis_dllp_tready_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tlp_tdata_i,
    input  logic [KEEP_WIDTH-1:0] s_axis_tlp_tkeep_i,
    input  logic                  s_axis_tlp_tvalid_i,
    input  logic                  s_axis_tlp_tlast_i,
    input  logic [USER_WIDTH-1:0] s_axis_tlp_tuser_i,
    output logic                  s_axis_tlp_tready_o,
    output logic [DATA_WIDTH-1:0] m_axis_phy_tdata_o,
    output logic [KEEP_WIDTH-1:0] m_axis_phy_tkchar_o,
    output logic [KEEP_WIDTH-1:0] m_axis_phy_tkeep_o,
    output logic                  m_axis_phy_tvalid_o,
    output logic                  m_axis_phy_tlast_o,
    input  logic                  m_axis_phy_tready_i,
    input  logic                  phy_link_up_i,
    output logic                  framing_err_o
);

    localparam int CW = $clog2(MAX_DLLP_BURST + 1);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("pcie_phy_tx_framer supports DATA_WIDTH == 32 only");
    end

    framer_state_e         r_state, w_state_nxt;
    logic [CW-1:0]         r_burst;
    logic                  r_first, r_null, r_d_inpkt, r_t_inpkt, r_err;
    logic [7:0]            r_carry;
    logic                  r_valid, r_last;
    logic [DATA_WIDTH-1:0] r_data;
    logic [KEEP_WIDTH-1:0] r_kchar;

    logic                  w_adv, w_drop, w_d_acc, w_t_acc, w_acc, w_is_tlp, w_last;
    logic                  w_grant_d, w_grant_t, w_short, w_null, w_mal, w_err, w_load;
    logic                  w_d_inpkt_nxt, w_t_inpkt_nxt;
    logic [DATA_WIDTH-1:0] w_beat, w_al_data;
    logic [KEEP_WIDTH-1:0] w_keep, w_al_kchar;
    beat_pos_e             w_pos;
    logic                  w_unused;

    assign w_unused = ^{s_axis_dllp_tuser_i, s_axis_tlp_tuser_i};

    assign w_adv    = !r_valid || m_axis_phy_tready_i;
    assign w_drop   = !phy_link_up_i || r_state == ST_DROP;
    assign s_axis_dllp_tready_o = w_drop || (r_state == ST_DLLP && w_adv);
    assign s_axis_tlp_tready_o  = w_drop || (r_state == ST_TLP && w_adv);

    assign w_d_acc  = !w_drop && r_state == ST_DLLP && s_axis_dllp_tvalid_i && w_adv;
    assign w_t_acc  = !w_drop && r_state == ST_TLP && s_axis_tlp_tvalid_i && w_adv;
    assign w_acc    = w_d_acc || w_t_acc;
    assign w_is_tlp = r_state == ST_TLP;

    assign w_beat = w_is_tlp ? s_axis_tlp_tdata_i : s_axis_dllp_tdata_i;
    assign w_keep = w_is_tlp ? s_axis_tlp_tkeep_i : s_axis_dllp_tkeep_i;
    assign w_last = w_is_tlp ? s_axis_tlp_tlast_i : s_axis_dllp_tlast_i;
    assign w_null = w_is_tlp && (r_null || s_axis_tlp_tuser_i[TUSER_NULLIFY_BIT]);
    assign w_pos  = r_first ? POS_FIRST : w_last ? POS_LAST : POS_MID;

    assign w_short = r_first && w_last;
    assign w_err   = w_acc && (w_short || w_mal);
    assign w_load  = w_acc && !w_short;

    // Burst limit only bites while a TLP is actually waiting.
    assign w_grant_d = r_state == ST_IDLE && phy_link_up_i && w_adv && s_axis_dllp_tvalid_i &&
                       (r_burst < CW'(MAX_DLLP_BURST) || !s_axis_tlp_tvalid_i);
    assign w_grant_t = r_state == ST_IDLE && phy_link_up_i && w_adv && !w_grant_d && s_axis_tlp_tvalid_i;

    assign w_d_inpkt_nxt = (s_axis_dllp_tvalid_i && s_axis_dllp_tready_o) ? !s_axis_dllp_tlast_i : r_d_inpkt;
    assign w_t_inpkt_nxt = (s_axis_tlp_tvalid_i && s_axis_tlp_tready_o) ? !s_axis_tlp_tlast_i : r_t_inpkt;

    pcie_tx_token_align u_align (
        .i_beat      (w_beat),
        .i_keep      (w_keep),
        .i_carry     (r_carry),
        .i_pos       (w_pos),
        .i_is_tlp    (w_is_tlp),
        .i_nullify   (w_null),
        .o_data      (w_al_data),
        .o_kchar     (w_al_kchar),
        .o_malformed (w_mal)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: w_state_nxt = w_grant_d ? ST_DLLP : w_grant_t ? ST_TLP : ST_IDLE;
            ST_DLLP: w_state_nxt = (w_d_acc && s_axis_dllp_tlast_i) ? ST_IDLE : ST_DLLP;
            ST_TLP:  w_state_nxt = (w_t_acc && s_axis_tlp_tlast_i) ? ST_IDLE : ST_TLP;
            ST_DROP: w_state_nxt = (!w_d_inpkt_nxt && !w_t_inpkt_nxt) ? ST_IDLE : ST_DROP;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!phy_link_up_i) w_state_nxt = ST_DROP;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_burst   <= '0;
            r_first   <= 1'b0;
            r_null    <= 1'b0;
            r_d_inpkt <= 1'b0;
            r_t_inpkt <= 1'b0;
            r_carry   <= 8'h00;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_d_inpkt <= w_d_inpkt_nxt;
            r_t_inpkt <= w_t_inpkt_nxt;
            r_burst   <= (r_state == ST_IDLE && !s_axis_tlp_tvalid_i) ? '0 :
                         w_grant_d ? r_burst + CW'(1) : w_grant_t ? '0 : r_burst;
            r_first   <= (w_grant_d || w_grant_t) ? 1'b1 : w_acc ? 1'b0 : r_first;
            r_null    <= (w_grant_d || w_grant_t) ? 1'b0 : w_t_acc ? w_null : r_null;
            r_carry   <= w_acc ? w_beat[31:24] : r_carry;
            r_err     <= w_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || !phy_link_up_i) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_kchar <= '0;
        end else if (w_adv) begin
            r_valid <= w_load;
            r_last  <= w_load && w_last;
            r_data  <= w_load ? w_al_data : r_data;
            r_kchar <= w_load ? w_al_kchar : r_kchar;
        end
    end

    assign m_axis_phy_tvalid_o = r_valid && phy_link_up_i;
    assign m_axis_phy_tkeep_o  = {KEEP_WIDTH{m_axis_phy_tvalid_o}};
    assign m_axis_phy_tdata_o  = r_data;
    assign m_axis_phy_tkchar_o = r_kchar;
    assign m_axis_phy_tlast_o  = r_last;
    assign framing_err_o       = r_err;

endmodule

// File: tb/tb_pcie_phy_tx_framer.sv
// tb_pcie_phy_tx_framer: directed stimulus with a scoreboard queue of expected framed words,
// checked by an independent output monitor.
module tb_pcie_phy_tx_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] dllp_tdata = '0, tlp_tdata = '0;
    logic [3:0]  dllp_tkeep = '0, tlp_tkeep = '0;
    logic        dllp_tvalid = 1'b0, tlp_tvalid = 1'b0, dllp_tlast = 1'b0, tlp_tlast = 1'b0;
    logic [2:0]  dllp_tuser = '0, tlp_tuser = '0;
    logic        dllp_tready, tlp_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkchar, m_tkeep;
    logic        m_tvalid, m_tlast;
    logic        m_tready = 1'b1;
    logic        link = 1'b1;
    logic        framing_err;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    logic [40:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [40:0] held = '0;

    always #5 clk = ~clk;

    pcie_phy_tx_framer dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .s_axis_dllp_tdata_i  (dllp_tdata),
        .s_axis_dllp_tkeep_i  (dllp_tkeep),
        .s_axis_dllp_tvalid_i (dllp_tvalid),
        .s_axis_dllp_tlast_i  (dllp_tlast),
        .s_axis_dllp_tuser_i  (dllp_tuser),
        .s_axis_dllp_tready_o (dllp_tready),
        .s_axis_tlp_tdata_i   (tlp_tdata),
        .s_axis_tlp_tkeep_i   (tlp_tkeep),
        .s_axis_tlp_tvalid_i  (tlp_tvalid),
        .s_axis_tlp_tlast_i   (tlp_tlast),
        .s_axis_tlp_tuser_i   (tlp_tuser),
        .s_axis_tlp_tready_o  (tlp_tready),
        .m_axis_phy_tdata_o   (m_tdata),
        .m_axis_phy_tkchar_o  (m_tkchar),
        .m_axis_phy_tkeep_o   (m_tkeep),
        .m_axis_phy_tvalid_o  (m_tvalid),
        .m_axis_phy_tlast_o   (m_tlast),
        .m_axis_phy_tready_i  (m_tready),
        .phy_link_up_i        (link),
        .framing_err_o        (framing_err)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] kc, input logic l);
        exp_q.push_back({4'hF, kc, l, d});
    endtask

    // Word = {tkeep, tkchar, tlast, tdata}; a stalled word must reappear unchanged.
    always @(negedge clk) begin
        if (!rst) begin
            if (framing_err) err_seen++;
            if (stalled && m_tvalid) check("stall_stable", {m_tkeep, m_tkchar, m_tlast, m_tdata}, held);
            stalled = m_tvalid && !m_tready;
            held    = {m_tkeep, m_tkchar, m_tlast, m_tdata};
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", m_tdata);
                end else begin
                    check("word", {m_tkeep, m_tkchar, m_tlast, m_tdata}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic d_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        dllp_tdata = d; dllp_tkeep = k; dllp_tlast = l; dllp_tvalid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk); #1;
            if (dllp_tready) begin
                @(posedge clk); #1;
                dllp_tvalid = 1'b0;
                return;
            end
        end
        fail_now("dllp_ready");
        dllp_tvalid = 1'b0;
    endtask

    task automatic t_beat(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [2:0] u);
        tlp_tdata = d; tlp_tkeep = k; tlp_tlast = l; tlp_tuser = u; tlp_tvalid = 1'b1;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk); #1;
            if (tlp_tready) begin
                @(posedge clk); #1;
                tlp_tvalid = 1'b0;
                return;
            end
        end
        fail_now("tlp_ready");
        tlp_tvalid = 1'b0;
    endtask

    task automatic send_dllp(input logic [31:0] w0, input logic [31:0] w1, input logic [3:0] k1);
        d_beat(w0, 4'hF, 1'b0);
        d_beat(w1, k1, 1'b1);
    endtask

    task automatic send_tlp(input logic [31:0] b[4], input int n, input logic [3:0] klast, input logic [2:0] ulast);
        for (int i = 0; i < n; i++)
            t_beat(b[i], (i == n - 1) ? klast : 4'hF, i == n - 1, (i == n - 1) ? ulast : 3'b000);
    endtask

    task automatic drain();
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                repeat (3) @(posedge clk);
                #1;
                return;
            end
        end
        fail_now("drain");
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got hang expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tkeep", m_tkeep, 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tkchar_tlast", {m_tkchar, m_tlast}, 0);
        check("rst_err", framing_err, 0);
        check("rst_treadys", {dllp_tready, tlp_tready}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic DLLP with one-cycle latency
        push(32'h3322115C, 4'b0001, 1'b0);
        push(32'hFD665544, 4'b1000, 1'b1);
        d_beat(32'h44332211, 4'hF, 1'b0);
        check("dllp_latency", m_tvalid, 1);
        d_beat(32'h00006655, 4'b0011, 1'b1);
        drain();
        check("err_dllp", err_seen, 0);

        // 14-byte TLP
        push(32'h020100FB, 4'b0001, 1'b0);
        push(32'h06050403, 4'b0000, 1'b0);
        push(32'h0A090807, 4'b0000, 1'b0);
        push(32'hFD0D0C0B, 4'b1000, 1'b1);
        send_tlp('{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h00000D0C}, 4, 4'b0011, 3'b000);
        drain();
        check("err_tlp", err_seen, 0);

        // Nullified TLP gets EDB without a framing error
        push(32'h121110FB, 4'b0001, 1'b0);
        push(32'h16151413, 4'b0000, 1'b0);
        push(32'hFE191817, 4'b1000, 1'b1);
        send_tlp('{32'h13121110, 32'h17161514, 32'h00001918, 32'h0}, 3, 4'b0011, 3'b001);
        drain();
        check("err_nullify", err_seen, 0);

        // Burst fairness: D,D,D,D,T,D,D
        for (int i = 0; i < 4; i++) begin
            push(32'h3322115C, 4'b0001, 1'b0);
            push({8'hFD, 16'h6655, 8'(8'hA0 + i)}, 4'b1000, 1'b1);
        end
        push(32'h434241FB, 4'b0001, 1'b0);
        push(32'hFD464544, 4'b1000, 1'b1);
        for (int i = 4; i < 6; i++) begin
            push(32'h3322115C, 4'b0001, 1'b0);
            push({8'hFD, 16'h6655, 8'(8'hA0 + i)}, 4'b1000, 1'b1);
        end
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send_dllp({8'(8'hA0 + i), 24'h332211}, 32'h00006655, 4'b0011);
            end
            send_tlp('{32'h44434241, 32'h00004645, 32'h0, 32'h0}, 2, 4'b0011, 3'b000);
        join
        drain();

        // Backpressure toggling
        push(32'h222120FB, 4'b0001, 1'b0);
        push(32'h26252423, 4'b0000, 1'b0);
        push(32'h2A292827, 4'b0000, 1'b0);
        push(32'hFD2D2C2B, 4'b1000, 1'b1);
        fork
            send_tlp('{32'h23222120, 32'h27262524, 32'h2B2A2928, 32'h00002D2C}, 4, 4'b0011, 3'b000);
            begin
                repeat (16) begin
                    @(posedge clk); #1;
                    m_tready = !m_tready;
                end
            end
        join
        m_tready = 1'b1;
        drain();

        // Link drop mid-TLP: only the first word survives, the rest is drained silently
        push(32'h323130FB, 4'b0001, 1'b0);
        t_beat(32'h33323130, 4'hF, 1'b0, 3'b000);
        t_beat(32'h37363534, 4'hF, 1'b0, 3'b000);
        link = 1'b0;
        @(negedge clk);
        check("linkdown_tvalid", m_tvalid, 0);
        check("linkdown_treadys", {dllp_tready, tlp_tready}, 2'b11);
        @(posedge clk); #1;
        t_beat(32'h3B3A3938, 4'hF, 1'b0, 3'b000);
        t_beat(32'h00003D3C, 4'b0011, 1'b1, 3'b000);
        repeat (2) @(posedge clk);
        #1;
        link = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("linkdrop_queue", exp_q.size(), 0);
        push(32'h5352515C, 4'b0001, 1'b0);
        push(32'hFD565554, 4'b1000, 1'b1);
        send_dllp(32'h54535251, 32'h00005655, 4'b0011);
        drain();
        check("err_linkdrop", err_seen, 0);

        // Malformed last beats and a too-short packet
        push(32'h3322115C, 4'b0001, 1'b0);
        push(32'hFE665544, 4'b1000, 1'b1);
        send_dllp(32'h44332211, 32'hAABB6655, 4'b1111);
        drain();
        check("err_keep1111", err_seen, 1);
        push(32'h3322115C, 4'b0001, 1'b0);
        push(32'hFE005544, 4'b1000, 1'b1);
        send_dllp(32'h44332211, 32'hAABBCC55, 4'b0001);
        drain();
        check("err_keep0001", err_seen, 2);
        d_beat(32'hDEADBEEF, 4'hF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("short_no_word", m_tvalid, 0);
        check("err_short", err_seen, 3);
        push(32'h6362615C, 4'b0001, 1'b0);
        push(32'hFD666564, 4'b1000, 1'b1);
        send_dllp(32'h64636261, 32'h00006665, 4'b0011);
        drain();
        check("err_final", err_seen, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcie_phy_tx_framer.md
Name: pcie_phy_tx_framer

Overview:
- Sits directly downstream of the datalink layer and upstream of the 8b/10b PHY transmit lane logic.
- Merges the DLLP stream (dllp2phy) and the TLP stream (tlp2phy) into one symbol stream, arbitrating at packet boundaries.
- Wraps each DLLP in SDP/END tokens and each TLP in STP/END (or EDB) tokens, byte-realigning the payload.
- Marks every K-symbol with a per-byte K flag.

Parameters:
- DATA_WIDTH, 32, stream width; only 32 is supported, elaboration-time assertion otherwise.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- USER_WIDTH, 3, tuser width; bit 0 = nullify TLP.
- MAX_DLLP_BURST, 4, consecutive DLLP grants allowed while a TLP waits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- s_axis_dllp_tdata_i/tkeep_i/tvalid_i/tlast_i/tuser_i/tready_o  in/in/in/in/in/out  32/4/1/1/3/1  DLLP input; 6 bytes in 2 beats
- s_axis_tlp_tdata_i/tkeep_i/tvalid_i/tlast_i/tuser_i/tready_o  in/in/in/in/in/out  32/4/1/1/3/1  TLP input; seq(2)+TLP+LCRC(4) = 4n+6 bytes
- m_axis_phy_tdata_o  out  32  framed symbols, byte 0 = bits 7:0, first on wire
- m_axis_phy_tkchar_o  out  4  per-byte K-symbol flag
- m_axis_phy_tkeep_o  out  4  always 4'b1111 when valid
- m_axis_phy_tvalid_o/tlast_o  out  1/1  output handshake; tlast on the END/EDB word
- m_axis_phy_tready_i  in  1  PHY accept
- phy_link_up_i  in  1  link up
- framing_err_o  out  1  one-cycle pulse on a malformed packet

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all m_* outputs 0, s_*_tready_o 0, framing_err_o 0, FSM IDLE, burst counter 0, carry byte 0.
- Tokens: SDP=8'h5C, STP=8'hFB, END=8'hFD, EDB=8'hFE. tkchar=1 only on token bytes.
- FSM states: IDLE, DLLP, TLP, DROP.
- IDLE arbitration, evaluated only while output register empty or being accepted:
  - DLLP valid and (burst count < MAX_DLLP_BURST or no TLP valid) → DLLP; burst counter +1.
  - Else TLP valid → TLP; burst counter cleared.
  - Burst counter also clears whenever TLP valid is low in IDLE.
- Datapath: output is a single register stage. An input beat is accepted iff FSM is in the matching state and (output reg empty or m_tready). Latency is 1 cycle from input accept to output valid.
- First beat: out = {in[23:0], SDP|STP}, tkchar=4'b0001. Carry byte ← in[31:24].
- Middle beat: out = {in[23:0], carry}. Carry ← in[31:24].
- Last beat, keep must be 4'b0011: out = {END, in[15:0], carry}, tkchar=4'b1000, tlast=1. Output word count equals input word count.
- TLP with tuser[0]=1 on any beat: EDB replaces END.
- Malformed last beat (keep≠4'b0011): EDB replaces END, byte slots beyond keep are 8'h00, framing_err_o pulses.
- tlast on first beat (packet too short): whole beat consumed, no output, framing_err_o pulses, FSM returns to IDLE.
- Packet end: after the last beat is accepted, FSM returns to IDLE. The same cycle may grant the next packet if the output register is being accepted.
- Backpressure: m_axis_phy_tvalid_o holds with stable data until m_axis_phy_tready_i. Both tready_o outputs drop when the output register is full and not accepted.
- Link down: when phy_link_up_i is low, output tvalid is forced 0 and the output register is cleared.
  - FSM → DROP: both inputs tready=1 and are discarded.
  - DROP exits to IDLE once link is up and neither input is mid-packet, tracked per input by an in-packet flag.
  - A link drop mid-packet abandons the output packet with no END.
- Reset mid-packet: immediate return to reset values; the partial packet is lost.

Decomposition:
- pcie_datalink_pkg gains:
  - token constants SDP/STP/END/EDB
  - framer_state_e enum
  - TUSER_NULLIFY_BIT index
- One natural sub-module: pcie_tx_token_align, the combinational byte-shift/token-insert from {beat, carry, position, nullify}, unit-testable alone.
- FSM and arbitration stay in the top.

Test Plan:
- DLLP beats 32'h44332211 then keep 0011 32'h00006655 → out 32'h332211_5C tkchar 0001, then 32'hFD665544 tkchar 1000 tlast.
- TLP of 4 beats (4n+6=14 bytes) with m_tready held high → 4 output words, first starts with FB, last word carries END; 1-cycle latency each.
- TLP with tuser[0]=1 on the last beat → last word byte 3 = FE, framing_err_o stays 0.
- 6 DLLPs queued plus a TLP waiting, MAX_DLLP_BURST=4 → grant order D,D,D,D,T,D,D.
- m_tready toggled 1010… during a TLP → no word lost or duplicated; data stable while stalled.
- phy_link_up_i dropped mid-TLP → tvalid 0 next cycle, remaining input beats drained with tready=1.
- Link restored → next DLLP framed correctly.
- Last beat keep=4'b1111 → EDB in byte 3, framing_err_o single pulse.
